// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// A request is accepted in IDLE or DONE. Multiplies and divides run one bit per
// cycle in CALC, then FIX applies the sign and selects the result word.
// Divide-by-zero and signed overflow finish straight away.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            request strobe, sampled only in IDLE or DONE
//   funct_3          M-extension op select (MUL..REMU)
//   op_a, op_b       rs1/rs2 values, captured when a request is accepted
//   flush            abort any in-flight operation; has priority over start
//   busy             high while an accepted operation is in progress (stall)
//   done             one-cycle pulse, result valid
//   result           last completed result, held until the next write
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct_3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    // hi_q:lo_q holds the product, or the remainder:quotient, during CALC
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;

    logic            accept;
    logic            a_signed, b_signed, a_neg, b_neg, neg_c;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   hi_nxt, lo_nxt;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, fix_res;

    assign accept = start && !flush && (state == S_IDLE || state == S_DONE);

    // Operand signedness per op
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct_3)
            3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed && op_a[XLEN-1];
    assign b_neg = b_signed && op_b[XLEN-1];
    // INT_MIN negates to itself, which is the correct unsigned magnitude
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // Recorded result sign: remainder follows the dividend only
    always_comb begin
        neg_c = 1'b0;
        case (funct_3)
            3'b001, 3'b010, 3'b100: neg_c = a_neg ^ b_neg;
            3'b110:                 neg_c = a_neg;
            default:                neg_c = 1'b0;
        endcase
    end

    // Early-out divide cases
    assign div_zero = funct_3[2] && (op_b == '0);
    assign div_ovf  = funct_3[2] && !funct_3[0] && (op_a == INT_MIN) && (op_b == '1);
    assign special  = div_zero || div_ovf;
    always_comb begin
        special_res = '0;
        if (div_zero) special_res = funct_3[1] ? op_a : '1;
        else          special_res = funct_3[1] ? '0 : op_a;
    end

    // One iteration: shift-add multiply or restoring divide step
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        if (op_q[2]) begin
            hi_nxt = div_ge ? XLEN'(div_shift - {1'b0, b_q}) : div_shift[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and word select
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        div_raw  = op_q[1] ? hi_q : lo_q;
        div_fix  = neg_q ? -div_raw : div_raw;
        if (op_q[2])              fix_res = div_fix;
        else if (op_q[1:0] == '0) fix_res = prod_fix[XLEN-1:0];
        else                      fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) next_state = special ? S_DONE : S_CALC;
                S_CALC:  if (cnt == CNT_LAST) next_state = S_FIX;
                S_FIX:   next_state = S_DONE;
                S_DONE:  next_state = start ? (special ? S_DONE : S_CALC) : S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Registered status outputs track the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state == S_CALC) || (next_state == S_FIX);
            done <= (next_state == S_DONE);
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            result <= '0;
        end else if (accept) begin
            cnt   <= '0;
            op_q  <= funct_3;
            neg_q <= neg_c;
            hi_q  <= '0;
            lo_q  <= a_mag;
            b_q   <= b_mag;
            if (special) result <= special_res;
        end else if (!flush && state == S_CALC) begin
            cnt  <= cnt + CW'(1);
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end else if (!flush && state == S_FIX) begin
            result <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with a
// latency/flush tracker, directed cases from the RV32M rules, then random ops.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned LAT  = XLEN + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      funct_3 = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            flush = 1'b0;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct_3(funct_3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Plain-arithmetic RV32M reference; sp = finishes without iterating
    function automatic void ref_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output bit sp);
        longint      sa, sb, ua, ps;
        logic [63:0] pu;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'b0, a});
        sp = 1'b0;
        r  = '0;
        case (f)
            3'd0: begin ps = sa * sb; r = ps[31:0];  end
            3'd1: begin ps = sa * sb; r = ps[63:32]; end
            3'd2: begin ps = sa * longint'({32'b0, b}); r = ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            3'd4: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; sp = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; sp = 1'b1; end
                else begin ps = sa / sb; r = ps[31:0]; end
            end
            3'd5: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; sp = 1'b1; end
                else begin ps = ua / longint'({32'b0, b}); r = ps[31:0]; end
            end
            3'd6: begin
                if (b == 0) begin r = a; sp = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = '0; sp = 1'b1; end
                else begin ps = sa % sb; r = ps[31:0]; end
            end
            default: begin
                if (b == 0) begin r = a; sp = 1'b1; end
                else begin ps = ua % longint'({32'b0, b}); r = ps[31:0]; end
            end
        endcase
    endfunction

    // Expected outputs after each edge: accept, countdown to done, flush, reset
    logic            m_busy = 1'b0, m_done = 1'b0;
    logic [31:0]     m_result = '0, m_pend = '0, m_r;
    int              m_left = 0;
    bit              m_sp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_left = 0;
        end else if (flush) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else if (!m_busy && start) begin
            ref_calc(funct_3, op_a, op_b, m_r, m_sp);
            m_pend = m_r;
            if (m_sp) begin
                m_result = m_r; m_done = 1'b1;
            end else begin
                m_busy = 1'b1; m_done = 1'b0; m_left = XLEN + 1;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1; m_result = m_pend;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("result", result, m_result);
        end
    end

    task automatic pulse_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; funct_3 = f; op_a = a; op_b = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count negedges until done; n=1 is the cycle right after the accept edge
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                return;
            end
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        pulse_start(f, a, b);
        wait_done(n);
        chk({name, "_lat"}, 32'(n), 32'(lat));
        chk({name, "_res"}, result, exp);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          n, ones;
        logic [31:0] r;
        bit          sp, chain;

        // Pin the reference model with hand-computed values
        ref_calc(3'd0, 32'd7, 32'hFFFF_FFFD, r, sp);        chk("ref_mul", r, 32'hFFFF_FFEB);
        ref_calc(3'd2, 32'hFFFF_FFFF, 32'd2, r, sp);        chk("ref_mulhsu", r, 32'hFFFF_FFFF);
        ref_calc(3'd4, 32'hFFFF_FFF9, 32'd2, r, sp);        chk("ref_div", r, 32'hFFFF_FFFD);
        ref_calc(3'd6, 32'hFFFF_FFF9, 32'd2, r, sp);        chk("ref_rem", r, 32'hFFFF_FFFF);
        ref_calc(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, r, sp); chk("ref_rem_ovf_sp", 32'(sp), 32'd1);

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
        run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT);
        run_op("mulhu",  3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, LAT);
        run_op("mul0",   3'd0, 32'd0,          32'd12345,     32'd0,         LAT);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT);
        run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14,        LAT);
        run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2,         LAT);

        // Flush mid-DIV with a stray start inside CALC
        @(negedge clk);
        pulse_start(3'd4, 32'hFFFF_FF00, 32'd3);
        repeat (3) @(negedge clk);
        start = 1'b1; funct_3 = 3'd5; op_a = 32'd9; op_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        ones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ones++;
        end
        chk("flush_no_done", 32'(ones), 32'd0);
        chk("flush_keep_res", result, 32'd2);
        run_op("after_flush", 3'd5, 32'd100, 32'd7, 32'd14, LAT);

        // Early-out divides
        run_op("divu_by0", 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",  3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        pulse_start(3'd0, 32'd6, 32'd7);
        wait_done(n);
        chk("b2b_first", result, 32'd42);
        pulse_start(3'd5, 32'd1000, 32'd10);
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b_lat", 32'(n + 1), 32'(LAT));
        chk("b2b_res", result, 32'd100);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        pulse_start(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);

        // Random ops with occasional flush, stray start and back-to-back issue
        chain = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!chain) @(negedge clk);
            chain = 1'b0;
            pulse_start(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 36)) @(negedge clk);
                flush = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    start = 1'b1; funct_3 = 3'd5; op_a = $urandom; op_b = 32'd3;
                end
                @(posedge clk);
                #1 flush = 1'b0; start = 1'b0;
            end else begin
                if ($urandom_range(0, 4) == 0) begin
                    repeat (2) @(negedge clk);
                    start = 1'b1; funct_3 = 3'($urandom_range(0, 7)); op_a = rnd_val(); op_b = rnd_val();
                    @(posedge clk);
                    #1 start = 1'b0;
                end
                wait_done(n);
                chain = ($urandom_range(0, 2) == 0);
            end
        end
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
